// File: rtl/collision_detector.sv
// Snake body buffer and move engine: advances the head per move strobe, checks walls,
// body (one segment per cycle) and apple, then commits and emits one event pulse.
module collision_detector #(
  parameter int unsigned GRID_W   = 16,
  parameter int unsigned GRID_H   = 16,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned START_X  = 8,
  parameter int unsigned START_Y  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       moveStrobe,
  input  logic [1:0] dir,
  input  logic [7:0] applePos,
  input  logic       isGameComplete,
  output logic       goodColl,
  output logic       badColl,
  output logic [7:0] headPos,
  output logic [4:0] snakeLen,
  output logic       busy
);

  localparam int unsigned CW = 4;
  localparam int unsigned PW = 2 * CW;
  localparam int unsigned LW = 5;
  localparam int unsigned IW = $clog2(MAX_LEN);

  localparam logic [1:0] H_UP    = 2'd0;
  localparam logic [1:0] H_RIGHT = 2'd1;
  localparam logic [1:0] H_DOWN  = 2'd2;
  localparam logic [1:0] H_LEFT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_SCAN,
    S_COMMIT,
    S_DEAD
  } state_e;

  state_e          state_q;
  logic [1:0]      heading_q;
  logic [LW-1:0]   len_q;
  logic [IW-1:0]   idx_q;
  logic [PW-1:0]   next_head_q;
  logic [PW-1:0]   body_q [MAX_LEN];

  logic [CW-1:0]   head_x;
  logic [CW-1:0]   head_y;
  logic [PW-1:0]   next_head_c;
  logic            wall_hit_c;

  assign head_x   = body_q[0][CW-1:0];
  assign head_y   = body_q[0][PW-1:CW];
  assign headPos  = body_q[0];
  assign snakeLen = len_q;

  // Candidate head one cell along the heading, plus wall detection.
  always_comb begin
    next_head_c = body_q[0];
    wall_hit_c  = 1'b0;
    case (heading_q)
      H_UP: begin
        wall_hit_c  = (head_y == '0);
        next_head_c = {head_y - CW'(1), head_x};
      end
      H_RIGHT: begin
        wall_hit_c  = (head_x == CW'(GRID_W - 1));
        next_head_c = {head_y, head_x + CW'(1)};
      end
      H_DOWN: begin
        wall_hit_c  = (head_y == CW'(GRID_H - 1));
        next_head_c = {head_y + CW'(1), head_x};
      end
      default: begin
        wall_hit_c  = (head_x == '0);
        next_head_c = {head_y, head_x - CW'(1)};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      heading_q   <= H_RIGHT;
      len_q       <= LW'(INIT_LEN);
      idx_q       <= '0;
      next_head_q <= '0;
      goodColl    <= 1'b0;
      badColl     <= 1'b0;
      busy        <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        body_q[i] <= (i < INIT_LEN) ? {CW'(START_Y), CW'(START_X - i)} : '0;
      end
    end else begin
      goodColl <= 1'b0;
      badColl  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (moveStrobe && !isGameComplete) begin
            // A direct reversal would fold the head onto the neck; keep heading instead.
            if (dir != (heading_q ^ 2'b10)) heading_q <= dir;
            state_q <= S_CALC;
            busy    <= 1'b1;
          end
        end
        S_CALC: begin
          if (wall_hit_c) begin
            state_q <= S_DEAD;
            badColl <= 1'b1;
            busy    <= 1'b0;
          end else begin
            next_head_q <= next_head_c;
            idx_q       <= '0;
            state_q     <= S_SCAN;
          end
        end
        S_SCAN: begin
          // The tail segment is never scanned: it vacates on this move.
          if (body_q[idx_q] == next_head_q) begin
            state_q <= S_DEAD;
            badColl <= 1'b1;
            busy    <= 1'b0;
          end else if (LW'(idx_q) == len_q - LW'(2)) begin
            state_q <= S_COMMIT;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_COMMIT: begin
          for (int unsigned i = MAX_LEN - 1; i > 0; i--) begin
            body_q[i] <= body_q[i-1];
          end
          body_q[0] <= next_head_q;
          if (next_head_q == applePos) begin
            goodColl <= 1'b1;
            if (len_q < LW'(MAX_LEN)) len_q <= len_q + LW'(1);
          end
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
        S_DEAD: begin
          state_q <= S_DEAD;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Bench for collision_detector: directed scenarios plus random walks, checked against
// a queue-based snake model that predicts pulse type, pulse cycle and final body.
module tb_collision_detector;

  localparam int GRID_W   = 16;
  localparam int GRID_H   = 16;
  localparam int MAX_LEN  = 16;
  localparam int INIT_LEN = 3;
  localparam int START_X  = 8;
  localparam int START_Y  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       moveStrobe = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [7:0] applePos = 8'h00;
  logic       isGameComplete = 1'b0;
  logic       goodColl;
  logic       badColl;
  logic [7:0] headPos;
  logic [4:0] snakeLen;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] m_body[$];
  int         m_len;
  int         m_dir;
  bit         m_dead;

  collision_detector #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_LEN(MAX_LEN),
    .INIT_LEN(INIT_LEN), .START_X(START_X), .START_Y(START_Y)
  ) dut (
    .clk(clk), .rst(rst), .moveStrobe(moveStrobe), .dir(dir),
    .applePos(applePos), .isGameComplete(isGameComplete),
    .goodColl(goodColl), .badColl(badColl), .headPos(headPos),
    .snakeLen(snakeLen), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_body.delete();
    for (int i = 0; i < INIT_LEN; i++) m_body.push_back({4'(START_Y), 4'(START_X - i)});
    m_len  = INIT_LEN;
    m_dir  = 1;
    m_dead = 1'b0;
  endtask

  // Predict one strobe: lat = cycles after the accepting edge until the move finishes (0: ignored).
  task automatic model_step(input logic [1:0] d, input logic [7:0] apple, input bit gc,
                            output int lat, output bit eg, output bit eb);
    int nx, ny;
    logic [7:0] nh;
    lat = 0; eg = 1'b0; eb = 1'b0;
    if (m_dead || gc) return;
    if (int'(d) != (m_dir + 2) % 4) m_dir = int'(d);
    nx = int'(m_body[0][3:0]);
    ny = int'(m_body[0][7:4]);
    case (m_dir)
      0: ny = ny - 1;
      1: nx = nx + 1;
      2: ny = ny + 1;
      default: nx = nx - 1;
    endcase
    if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
      lat = 1; eb = 1'b1; m_dead = 1'b1;
      return;
    end
    nh = {4'(ny), 4'(nx)};
    for (int i = 0; i < m_len - 1; i++) begin
      if (m_body[i] == nh) begin
        lat = 2 + i; eb = 1'b1; m_dead = 1'b1;
        return;
      end
    end
    lat = m_len + 1;
    m_body.push_front(nh);
    if (nh == apple) begin
      eg = 1'b1;
      if (m_len < MAX_LEN) m_len++;
    end
    while (m_body.size() > m_len) void'(m_body.pop_back());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    moveStrobe = 1'b0;
    isGameComplete = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_head", 32'(headPos), 32'(m_body[0]));
    chk("rst_len", 32'(snakeLen), 32'(m_len));
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", 32'({goodColl, badColl}), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_move(input logic [1:0] d, input logic [7:0] apple, input bit gc, input bit extra);
    int lat, budget, gcnt, bcnt, gat, bat, both;
    bit eg, eb;
    model_step(d, apple, gc, lat, eg, eb);
    @(negedge clk);
    dir = d; applePos = apple; isGameComplete = gc; moveStrobe = 1'b1;
    @(posedge clk);
    #1 moveStrobe = 1'b0;
    chk("busy_start", 32'(busy), 32'(lat > 0));
    gcnt = 0; bcnt = 0; gat = -1; bat = -1; both = 0;
    budget = lat + MAX_LEN + 4;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (extra && c == 1 && lat >= 2) begin
        moveStrobe = 1'b1;
        dir = 2'($urandom_range(0, 3));
      end else begin
        moveStrobe = 1'b0;
      end
      if (goodColl === 1'b1) begin gcnt++; if (gat < 0) gat = c; end
      if (badColl === 1'b1)  begin bcnt++; if (bat < 0) bat = c; end
      if (goodColl === 1'b1 && badColl === 1'b1) both++;
      if (lat > 0 && c == lat) chk("busy_end", 32'(busy), 0);
    end
    moveStrobe = 1'b0;
    chk("good_count", 32'(gcnt), 32'(eg));
    chk("bad_count", 32'(bcnt), 32'(eb));
    chk("both_pulses", 32'(both), 0);
    if (eg) chk("good_cycle", 32'(gat), 32'(lat));
    if (eb) chk("bad_cycle", 32'(bat), 32'(lat));
    chk("head", 32'(headPos), 32'(m_body[0]));
    chk("len", 32'(snakeLen), 32'(m_len));
    isGameComplete = 1'b0;
  endtask

  // Cell one step ahead of the model head for a requested dir, or -1 if off-grid.
  function automatic int front_cell(input logic [1:0] d);
    int h, nx, ny;
    h = (int'(d) == (m_dir + 2) % 4) ? m_dir : int'(d);
    nx = int'(m_body[0][3:0]);
    ny = int'(m_body[0][7:4]);
    case (h)
      0: ny = ny - 1;
      1: nx = nx + 1;
      2: ny = ny + 1;
      default: nx = nx - 1;
    endcase
    if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) return -1;
    return ny * 16 + nx;
  endfunction

  initial begin
    do_reset();

    // Apple straight ahead, then a reversal request that must be ignored
    do_move(2'd1, 8'h89, 1'b0, 1'b0);
    do_move(2'd3, 8'h00, 1'b0, 1'b0);

    // Walk into the right wall, then strobes in DEAD
    do_reset();
    for (int i = 0; i < 8; i++) do_move(2'd1, 8'h00, 1'b0, 1'b0);
    do_move(2'd1, 8'h00, 1'b0, 1'b0);
    do_move(2'd2, 8'h00, 1'b0, 1'b0);

    // Grow to 5, then down, left, up into own body
    do_reset();
    do_move(2'd1, 8'h89, 1'b0, 1'b0);
    do_move(2'd1, 8'h8A, 1'b0, 1'b0);
    do_move(2'd2, 8'h00, 1'b0, 1'b0);
    do_move(2'd3, 8'h00, 1'b0, 1'b0);
    do_move(2'd0, 8'h00, 1'b0, 1'b0);

    // Extra strobe while busy, game-complete freeze, and saturation at MAX_LEN
    do_reset();
    do_move(2'd1, 8'h00, 1'b0, 1'b1);
    do_move(2'd2, 8'h00, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 7; i++) do_move(2'd1, 8'(front_cell(2'd1)), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) do_move(2'd2, 8'(front_cell(2'd2)), 1'b0, 1'b0);

    // Reset in the middle of a move: no pulse, reset values restored
    do_reset();
    @(negedge clk);
    dir = 2'd1; applePos = 8'h89; moveStrobe = 1'b1;
    @(posedge clk);
    #1 moveStrobe = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_head", 32'(headPos), 32'h88);
    chk("midrst_len", 32'(snakeLen), 32'd3);
    chk("midrst_busy", 32'(busy), 0);
    begin
      int pulses = 0;
      @(negedge clk) rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk);
        #1 if (goodColl === 1'b1 || badColl === 1'b1) pulses++;
      end
      chk("midrst_pulses", 32'(pulses), 0);
    end
    do_reset();

    // Random walks with apples often placed straight ahead
    for (int n = 0; n < 160; n++) begin
      logic [1:0] d;
      logic [7:0] a;
      int fc;
      if (m_dead) do_reset();
      d  = 2'($urandom_range(0, 3));
      fc = front_cell(d);
      a  = ($urandom_range(0, 1) == 1 && fc >= 0) ? 8'(fc) : 8'($urandom_range(0, 255));
      do_move(d, a, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
